// File: rtl/byte_match_ctrl_if.sv
// Byte-stream / comparator bundle for the PRBS-15 byte-match sequencer.
// The master side feeds bytes and the comparator result; the slave is the sequencer.
interface byte_match_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             clear;
  logic             data_valid;
  logic [7:0]       data_in;
  logic             cmp_true_byte;
  logic             cmp_enable;
  logic [1:0]       cmp_byte_num;
  logic [7:0]       cmp_byte;
  logic             pattern_found;
  logic             mismatch;
  logic [CNT_W-1:0] match_count;
  logic             busy;

  modport master (
    output clear, data_valid, data_in, cmp_true_byte,
    input  cmp_enable, cmp_byte_num, cmp_byte, pattern_found, mismatch, match_count, busy
  );

  modport slave (
    input  clear, data_valid, data_in, cmp_true_byte,
    output cmp_enable, cmp_byte_num, cmp_byte, pattern_found, mismatch, match_count, busy
  );
endinterface

// File: rtl/byte_match_ctrl.sv
// Sequences received bytes into a registered byte comparator, tags each byte with lane/epoch,
// and counts consecutive 32-bit pattern matches to declare lock.
module byte_match_ctrl #(
  parameter int NUM_PATTERNS = 4,
  parameter int CNT_W        = 8
) (
  input logic              clk,
  input logic              rst,
  byte_match_ctrl_if.slave bus
);
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, LOCK} state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic              epoch;
  logic              pok;
  logic [CNT_W-1:0]  count;
  logic              pattern_found;
  logic              mismatch;
  logic              busy;

  logic              vld_p0;
  logic [1:0]        lane_p0;
  logic              epoch_p0;
  logic [DATA_W-1:0] byte_p0;

  logic              vld_p1;
  logic [1:0]        lane_p1;
  logic              epoch_p1;

  logic              res_live;
  logic              mm_evt;
  logic              hit_evt;
  logic              lock_hit;
  logic              epoch_nx;
  logic [1:0]        idx_base;
  logic [CNT_W-1:0]  cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Check stage: results whose epoch predates the last mismatch/clear are stale
  always_comb begin
    res_live = vld_p1 && (epoch_p1 == epoch);
    mm_evt   = res_live && !bus.cmp_true_byte;
    hit_evt  = res_live && bus.cmp_true_byte && (lane_p1 == 2'd3) && pok;
    cnt_inc  = sat_inc(count);
    lock_hit = hit_evt && (32'(cnt_inc) >= 32'(NUM_PATTERNS));
    epoch_nx = mm_evt ? ~epoch : epoch;
    idx_base = mm_evt ? 2'd0 : byte_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      byte_idx      <= 2'd0;
      epoch         <= 1'b0;
      pok           <= 1'b1;
      count         <= '0;
      pattern_found <= 1'b0;
      mismatch      <= 1'b0;
      busy          <= 1'b0;
      vld_p0        <= 1'b0;
      lane_p0       <= 2'd0;
      epoch_p0      <= 1'b0;
      byte_p0       <= '0;
      vld_p1        <= 1'b0;
      lane_p1       <= 2'd0;
      epoch_p1      <= 1'b0;
    end else if (bus.clear) begin
      state         <= IDLE;
      byte_idx      <= 2'd0;
      epoch         <= ~epoch;
      pok           <= 1'b1;
      count         <= '0;
      pattern_found <= 1'b0;
      mismatch      <= 1'b0;
      busy          <= 1'b0;
      vld_p0        <= 1'b0;
      lane_p0       <= 2'd0;
      byte_p0       <= '0;
      vld_p1        <= 1'b0;
    end else begin
      // Issue stage -> p0: a mismatch forces this byte to lane 0 under the new epoch
      vld_p0 <= bus.data_valid;
      epoch  <= epoch_nx;
      if (bus.data_valid) begin
        byte_p0  <= bus.data_in;
        lane_p0  <= idx_base;
        epoch_p0 <= epoch_nx;
        byte_idx <= idx_base + 2'd1;
      end else begin
        byte_idx <= idx_base;
      end

      // p0 -> p1: tag travels alongside the comparator's registered result
      vld_p1   <= vld_p0;
      lane_p1  <= lane_p0;
      epoch_p1 <= epoch_p0;

      // Update stage: count, partial-OK, mismatch pulse and lock FSM
      mismatch <= mm_evt;
      if (mm_evt) begin
        count <= '0;
        pok   <= 1'b1;
      end else if (res_live) begin
        if (lane_p1 == 2'd3) begin
          if (hit_evt) count <= cnt_inc;
          pok <= 1'b1;
        end else begin
          pok <= pok & bus.cmp_true_byte;
        end
      end

      case (state)
        IDLE: begin
          if (bus.data_valid) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (lock_hit) begin
            state         <= LOCK;
            pattern_found <= 1'b1;
          end
        end
        LOCK: begin
          if (mm_evt) begin
            state         <= RUN;
            pattern_found <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmp_enable    = vld_p0;
  assign bus.cmp_byte_num  = lane_p0;
  assign bus.cmp_byte      = byte_p0;
  assign bus.pattern_found = pattern_found;
  assign bus.mismatch      = mismatch;
  assign bus.match_count   = count;
  assign bus.busy          = busy;
endmodule
